alu_lockstep_ctrl: RTL and testbench

ALU_LOCKSTEP_CTRL -- requirements
Module: alu_lockstep_ctrl

---
 rtl/alu_lockstep_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_alu_lockstep_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_lockstep_ctrl.sv
// Dual-ALU lockstep controller: round-robin intake from two requesters, one retry on mismatch.
// Optional saturating mismatch counter is built when ALU_FAULT_CNT_EN is defined.

module alu_lockstep_alu (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [1:0] sel_i,
    output logic [4:0] res_o
);
    always_comb begin
        res_o = '0;
        case (sel_i)
            2'b00:   res_o = {1'b0, a_i} + {1'b0, b_i};
            2'b01:   res_o = {1'b0, a_i} - {1'b0, b_i};
            2'b10:   res_o = {1'b0, a_i & b_i};
            default: res_o = {1'b0, a_i | b_i};
        endcase
    end
endmodule

// state | meaning
// IDLE  | ready offered to the granted requester, waiting for a handshake
// EXEC  | both ALU copies evaluate latched operands; one retry on mismatch
// RESP  | response held until the consumer takes it
module alu_lockstep_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [1:0] req0_sel,
    input  logic [1:0] req1_sel,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_out,
    output logic       rsp_carry,
    output logic       rsp_fault,
    input  logic       inj_en,
    input  logic [4:0] inj_mask,
    output logic       fault_sticky,
    input  logic       clr_fault,
    output logic [7:0] fault_cnt
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t     state_q;
    logic [3:0] op_a_q;
    logic [3:0] op_b_q;
    logic [1:0] op_sel_q;
    logic       id_q;
    logic       retry_q;
    logic       prio_q;
    logic       rsp_valid_q;
    logic       rsp_id_q;
    logic [3:0] rsp_out_q;
    logic       rsp_carry_q;
    logic       rsp_fault_q;
    logic       fault_sticky_q;
    logic       fault_sticky_d;

    logic [1:0] grant;
    logic [4:0] res1;
    logic [4:0] res2;
    logic [4:0] res2_chk;
    logic       mismatch;
    logic       fault_set;

    // prio_q names the requester that wins a tie; it flips away from each grant.
    always_comb begin
        grant = 2'b00;
        if (req0_valid && req1_valid) begin
            grant = prio_q ? 2'b10 : 2'b01;
        end else begin
            grant = {req1_valid, req0_valid};
        end
    end

    assign req0_ready = (state_q == S_IDLE) && grant[0];
    assign req1_ready = (state_q == S_IDLE) && grant[1];

    alu_lockstep_alu u_alu1 (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sel_i (op_sel_q),
        .res_o (res1)
    );

    alu_lockstep_alu u_alu2 (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sel_i (op_sel_q),
        .res_o (res2)
    );

    assign res2_chk  = res2 ^ (inj_en ? inj_mask : 5'b00000);
    assign mismatch  = (res1 != res2_chk);
    assign fault_set = (state_q == S_EXEC) && mismatch && retry_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_sel_q    <= '0;
            id_q        <= 1'b0;
            retry_q     <= 1'b0;
            prio_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_out_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_fault_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant != 2'b00) begin
                        op_a_q   <= grant[1] ? req1_a   : req0_a;
                        op_b_q   <= grant[1] ? req1_b   : req0_b;
                        op_sel_q <= grant[1] ? req1_sel : req0_sel;
                        id_q     <= grant[1];
                        prio_q   <= ~grant[1];
                        retry_q  <= 1'b0;
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (mismatch && !retry_q) begin
                        retry_q <= 1'b1;
                    end else begin
                        // Copy 1 is reported even when lockstep fails; the fault bit flags it.
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_out_q   <= res1[3:0];
                        rsp_carry_q <= res1[4];
                        rsp_fault_q <= mismatch;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        fault_sticky_d = fault_sticky_q;
        if (fault_set) begin
            fault_sticky_d = 1'b1;
        end else if (clr_fault) begin
            fault_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_sticky_q <= 1'b0;
        end else begin
            fault_sticky_q <= fault_sticky_d;
        end
    end

`ifdef ALU_FAULT_CNT_EN
    logic [7:0] fault_cnt_q;
    logic [7:0] fault_cnt_d;
    logic       cnt_inc;

    assign cnt_inc = (state_q == S_EXEC) && mismatch;

    // A mismatch in the same cycle as a clear restarts the count at one.
    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if (clr_fault) begin
            fault_cnt_d = cnt_inc ? 8'd1 : 8'd0;
        end else if (cnt_inc && (fault_cnt_q != 8'hff)) begin
            fault_cnt_d = fault_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_cnt_q <= '0;
        end else begin
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign fault_cnt = fault_cnt_q;
`else
    assign fault_cnt = 8'd0;
`endif

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_out      = rsp_out_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_fault    = rsp_fault_q;
    assign fault_sticky = fault_sticky_q;

endmodule

// File: tb/tb_alu_lockstep_ctrl.sv
// Directed self-checking bench for alu_lockstep_ctrl; expected values are hand-computed.
// Expected fault counts follow ALU_FAULT_CNT_EN.

module tb_alu_lockstep_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_sel, req1_sel;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [3:0] rsp_out;
    logic       rsp_carry, rsp_fault;
    logic       inj_en;
    logic [4:0] inj_mask;
    logic       fault_sticky, clr_fault;
    logic [7:0] fault_cnt;

`ifdef ALU_FAULT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_lockstep_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req1_valid   (req1_valid),
        .req0_ready   (req0_ready),
        .req1_ready   (req1_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req0_sel     (req0_sel),
        .req1_sel     (req1_sel),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_out      (rsp_out),
        .rsp_carry    (rsp_carry),
        .rsp_fault    (rsp_fault),
        .inj_en       (inj_en),
        .inj_mask     (inj_mask),
        .fault_sticky (fault_sticky),
        .clr_fault    (clr_fault),
        .fault_cnt    (fault_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check_eq({tag, "_rsp_id"}, 32'(rsp_id), 0);
        check_eq({tag, "_rsp_out"}, 32'(rsp_out), 0);
        check_eq({tag, "_rsp_carry"}, 32'(rsp_carry), 0);
        check_eq({tag, "_rsp_fault"}, 32'(rsp_fault), 0);
        check_eq({tag, "_sticky"}, 32'(fault_sticky), 0);
        check_eq({tag, "_cnt"}, 32'(fault_cnt), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_reset_outputs("reset");
        step();
        step();
        rst = 1'b0;
    endtask

    // Starts in the driving phase of an IDLE cycle; returns on the negedge where rsp_valid is expected.
    task automatic run_op(input string tag, input bit id, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] sel, input bit inj1, input bit inj2, input int lat,
                          input logic [3:0] eout, input bit ecarry, input bit efault);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
        end
        @(negedge clk);
        check_eq({tag, "_ready"}, 32'(id ? req1_ready : req0_ready), 1);
        check_eq({tag, "_other_ready"}, 32'(id ? req0_ready : req1_ready), 0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        inj_en = inj1;
        @(negedge clk);
        check_eq({tag, "_valid_n1"}, 32'(rsp_valid), 0);
        step();
        inj_en = inj2;
        @(negedge clk);
        if (lat == 3) begin
            check_eq({tag, "_valid_n2"}, 32'(rsp_valid), 0);
            step();
            inj_en = 1'b0;
            @(negedge clk);
        end
        inj_en = 1'b0;
        check_eq({tag, "_valid"}, 32'(rsp_valid), 1);
        check_eq({tag, "_id"}, 32'(rsp_id), 32'(id));
        check_eq({tag, "_out"}, 32'(rsp_out), 32'(eout));
        check_eq({tag, "_carry"}, 32'(rsp_carry), 32'(ecarry));
        check_eq({tag, "_fault"}, 32'(rsp_fault), 32'(efault));
    endtask

    initial begin
        bit grants[4];
        int ng;

        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        req0_sel = 0; req1_sel = 0;
        rsp_ready = 1'b1;
        inj_en = 0; inj_mask = 0; clr_fault = 0;
        step();
        do_reset();
        step();

        run_op("add", 1'b0, 4'd9, 4'd8, 2'b00, 0, 0, 2, 4'd1, 1'b1, 1'b0);
        step();
        run_op("sub", 1'b1, 4'd3, 4'd5, 2'b01, 0, 0, 2, 4'd14, 1'b1, 1'b0);
        step();
        run_op("and", 1'b1, 4'd12, 4'd10, 2'b10, 0, 0, 2, 4'd8, 1'b0, 1'b0);
        step();

        inj_mask = 5'b00000;
        run_op("injzero", 1'b0, 4'd4, 4'd3, 2'b11, 1, 1, 2, 4'd7, 1'b0, 1'b0);
        check_eq("injzero_sticky", 32'(fault_sticky), 0);
        step();

        inj_mask = 5'b00001;
        run_op("injheld", 1'b0, 4'd9, 4'd8, 2'b00, 1, 1, 3, 4'd1, 1'b1, 1'b1);
        check_eq("injheld_sticky", 32'(fault_sticky), 1);
        check_eq("injheld_cnt", 32'(fault_cnt), CNT_ON ? 32'd2 : 32'd0);
        step();

        clr_fault = 1'b1;
        step();
        clr_fault = 1'b0;
        @(negedge clk);
        check_eq("clr_sticky", 32'(fault_sticky), 0);
        check_eq("clr_cnt", 32'(fault_cnt), 0);
        step();

        run_op("injpulse", 1'b1, 4'd7, 4'd2, 2'b01, 1, 0, 3, 4'd5, 1'b0, 1'b0);
        check_eq("injpulse_sticky", 32'(fault_sticky), 0);
        check_eq("injpulse_cnt", 32'(fault_cnt), CNT_ON ? 32'd1 : 32'd0);
        step();

        rsp_ready = 1'b0;
        run_op("hold", 1'b0, 4'd15, 4'd1, 2'b00, 0, 0, 2, 4'd0, 1'b1, 1'b0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(rsp_valid), 1);
            check_eq("hold_out", 32'(rsp_out), 0);
            check_eq("hold_carry", 32'(rsp_carry), 1);
            check_eq("hold_ready0", 32'(req0_ready), 0);
            check_eq("hold_ready1", 32'(req1_ready), 0);
        end
        rsp_ready = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        @(negedge clk);
        check_eq("hold_release", 32'(rsp_valid), 0);
        step();

        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                check_eq("rr_onehot", 32'(req0_ready) + 32'(req1_ready), 1);
                grants[ng] = req1_ready;
                ng++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check_eq("rr_count", 32'(ng), 4);
        check_eq("rr_g0", 32'(grants[0]), 0);
        check_eq("rr_g1", 32'(grants[1]), 1);
        check_eq("rr_g2", 32'(grants[2]), 0);
        check_eq("rr_g3", 32'(grants[3]), 1);
        repeat (5) step();

        clr_fault = 1'b1;
        inj_mask = 5'b00001;
        run_op("setclr", 1'b0, 4'd2, 4'd2, 2'b00, 1, 1, 3, 4'd4, 1'b0, 1'b1);
        check_eq("setclr_sticky", 32'(fault_sticky), 1);
        clr_fault = 1'b0;
        step();

        req0_a = 4'd9; req0_b = 4'd8; req0_sel = 2'b00;
        req0_valid = 1'b1;
        inj_en = 1'b1;
        repeat (600) step();
        req0_valid = 1'b0;
        repeat (6) step();
        inj_en = 1'b0;
        @(negedge clk);
        check_eq("sat_cnt", 32'(fault_cnt), CNT_ON ? 32'd255 : 32'd0);
        check_eq("sat_out", 32'(rsp_out), 1);
        step();

        req0_valid = 1'b1;
        @(negedge clk);
        check_eq("rstmid_ready", 32'(req0_ready), 1);
        step();
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("rstmid");
        check_eq("rstmid_ready0", 32'(req0_ready), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("rstmid_norsp", 32'(rsp_valid), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
